flash_boot_loader: RTL and testbench

- Boot-time copy engine that sits between the Flash controller (upstream) and the ExtRAM instruction-memory wrapper (downstream).
- Reads 16-bit halfwords from Flash through the controller's addr/data/data_ready interface.
- Packs each pair of halfwords into a 32-bit word and writes the words into instruction RAM.
- Holds the CPU in reset until the image is loaded, so the CPU boots from RAM populated from Flash.

---
 rtl/flash_boot_loader.sv | 142 ++++++++++++++
 tb/tb_flash_boot_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_boot_loader.sv
// Boot-time copy engine: streams 16-bit Flash halfwords into 32-bit instruction RAM
// words and holds the CPU in reset until the image has been loaded.
module flash_boot_loader #(
  parameter logic [21:0] FLASH_BASE     = 22'h0,
  parameter logic [31:0] RAM_BASE       = 32'h8000_0000,
  parameter int unsigned WORD_COUNT     = 1024,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned RAM_WR_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter bit          START_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic [21:0] flash_addr_o,
  input  logic [15:0] flash_data_i,
  input  logic        flash_data_ready_i,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic [3:0]  ram_sel_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cpu_hold_o,
  output logic [19:0] progress_o
);

  localparam logic [19:0] WC = 20'(WORD_COUNT);

  typedef enum logic [2:0] {
    IDLE, SET_LO, WAIT_LO, SET_HI, WAIT_HI, WRITE, DONE, ERROR
  } state_t;

  state_t      state, state_next;
  logic [31:0] settle_cnt, tmo_cnt, wr_cnt;
  logic [15:0] lo;
  logic        go, cap_lo, cap_hi, wr_end;
  logic        settle_done, tmo_hit, wr_last, last_word;

  assign settle_done = (settle_cnt == '0);
  assign tmo_hit     = (tmo_cnt == TIMEOUT_CYCLES - 1);
  assign wr_last     = (wr_cnt == RAM_WR_CYCLES - 1);
  assign last_word   = ((progress_o + 20'd1) == WC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    wr_end     = 1'b0;
    case (state)
      IDLE:        if (START_ON_RESET || start_i) go = 1'b1;
      DONE, ERROR: if (start_i) go = 1'b1;
      SET_LO:      state_next = WAIT_LO;
      WAIT_LO:
        if (settle_done) begin
          if (flash_data_ready_i) begin
            cap_lo     = 1'b1;
            state_next = SET_HI;
          end else if (tmo_hit) begin
            state_next = ERROR;
          end
        end
      SET_HI:      state_next = WAIT_HI;
      WAIT_HI:
        if (settle_done) begin
          if (flash_data_ready_i) begin
            cap_hi     = 1'b1;
            state_next = WRITE;
          end else if (tmo_hit) begin
            state_next = ERROR;
          end
        end
      WRITE:
        if (wr_last) begin
          wr_end     = 1'b1;
          state_next = last_word ? DONE : SET_LO;
        end
      default:     state_next = IDLE;
    endcase
    if (go) state_next = (WC == '0) ? DONE : SET_LO;
  end

  // Strobes and status decode straight from state so an async reset drops them at once.
  assign ram_ce_o   = (state == WRITE);
  assign ram_we_o   = (state == WRITE);
  assign ram_sel_o  = (state == WRITE) ? 4'b1111 : 4'b0000;
  assign done_o     = (state == DONE);
  assign error_o    = (state == ERROR);
  assign busy_o     = !(state inside {IDLE, DONE, ERROR});
  assign cpu_hold_o = (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_addr_o <= FLASH_BASE;
      ram_addr_o   <= RAM_BASE;
      ram_data_o   <= '0;
      progress_o   <= '0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      wr_cnt       <= '0;
      lo           <= '0;
    end else begin
      if (go) begin
        flash_addr_o <= FLASH_BASE;
        ram_addr_o   <= RAM_BASE;
        progress_o   <= '0;
      end
      if (state == SET_LO || state == SET_HI) begin
        settle_cnt <= SETTLE_CYCLES;
        tmo_cnt    <= '0;
      end
      if (state == WAIT_LO || state == WAIT_HI) begin
        if (!settle_done)             settle_cnt <= settle_cnt - 32'd1;
        else if (!flash_data_ready_i) tmo_cnt    <= tmo_cnt + 32'd1;
      end
      if (cap_lo) begin
        lo           <= flash_data_i;
        flash_addr_o <= flash_addr_o + 22'd1;
      end
      if (cap_hi) begin
        ram_data_o <= {flash_data_i, lo};
        wr_cnt     <= '0;
      end
      if (state == WRITE) wr_cnt <= wr_cnt + 32'd1;
      // Hi address 2k+1 steps to the next word's lo address 2k+2.
      if (wr_end) begin
        progress_o   <= progress_o + 20'd1;
        ram_addr_o   <= ram_addr_o + 32'd4;
        flash_addr_o <= flash_addr_o + 22'd1;
      end
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed self-checking bench for flash_boot_loader: copy, timing, timeout, reset, zero-length start.
module tb_flash_boot_loader;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned WRC    = 2;
  localparam int unsigned TMO    = 16;
  localparam int WORD_PERIOD     = 2 * (2 + SETTLE) + WRC;
  localparam int COPY_LAT        = 1 + 4 * WORD_PERIOD;
  localparam int ERR_LAT         = 2 + SETTLE + TMO;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, zstart;
  logic [21:0] faddr, z_faddr;
  logic [15:0] fdata, z_fdata;
  logic        fready;
  logic        ram_ce, ram_we, z_ce, z_we;
  logic [31:0] ram_addr, ram_data, z_raddr, z_rdata;
  logic [3:0]  ram_sel, z_sel;
  logic        busy, done, error, hold, z_busy, z_done, z_error, z_hold;
  logic [19:0] prog, z_prog;

  flash_boot_loader #(
    .WORD_COUNT(4), .SETTLE_CYCLES(SETTLE), .RAM_WR_CYCLES(WRC),
    .TIMEOUT_CYCLES(TMO), .START_ON_RESET(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .start_i(start),
    .flash_addr_o(faddr), .flash_data_i(fdata), .flash_data_ready_i(fready),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data),
    .ram_sel_o(ram_sel), .busy_o(busy), .done_o(done), .error_o(error),
    .cpu_hold_o(hold), .progress_o(prog)
  );

  flash_boot_loader #(
    .WORD_COUNT(0), .START_ON_RESET(1'b0)
  ) u_zero (
    .clk(clk), .rst(rst), .start_i(zstart),
    .flash_addr_o(z_faddr), .flash_data_i(z_fdata), .flash_data_ready_i(1'b1),
    .ram_ce_o(z_ce), .ram_we_o(z_we), .ram_addr_o(z_raddr), .ram_data_o(z_rdata),
    .ram_sel_o(z_sel), .busy_o(z_busy), .done_o(z_done), .error_o(z_error),
    .cpu_hold_o(z_hold), .progress_o(z_prog)
  );

  // Flash model: data = address; mode 0 raises ready 3 cycles after an address change,
  // mode 1 ties ready high, mode 2 never raises it.
  int          mode = 0;
  int          since = 0;
  logic [21:0] prev_addr = '0;
  assign fdata   = faddr[15:0];
  assign z_fdata = z_faddr[15:0];
  always @(posedge clk) begin
    if (faddr != prev_addr) since <= 0;
    else if (since < 15)    since <= since + 1;
    prev_addr <= faddr;
  end
  always_comb fready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (since >= 3);

  // RAM-side monitor.
  logic [31:0] b_addr[$], b_data[$];
  int          b_start[$], b_len[$];
  int          cyc = 0, cur_len = 0, unstable = 0, bad_sel = 0;
  int          done_cyc = -1, hold_cyc = -2, z_ce_seen = 0, z_moves = 0;
  logic        we_prev = 1'b0, done_prev = 1'b0, hold_prev = 1'b1;
  logic [31:0] la, ld;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_we) begin
      if (ram_sel !== 4'hF) bad_sel++;
      if (!we_prev) begin
        b_addr.push_back(ram_addr);
        b_data.push_back(ram_data);
        b_start.push_back(cyc);
        cur_len = 1;
      end else begin
        cur_len++;
        if (ram_addr !== la || ram_data !== ld) unstable++;
      end
      la = ram_addr;
      ld = ram_data;
    end else if (we_prev) begin
      b_len.push_back(cur_len);
    end
    we_prev = ram_we;
    if (done && !done_prev) done_cyc = cyc;
    if (!hold && hold_prev) hold_cyc = cyc;
    done_prev = done;
    hold_prev = hold;
    if (z_ce) z_ce_seen++;
    if (z_faddr != 22'h0) z_moves++;
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    b_addr.delete(); b_data.delete(); b_start.delete(); b_len.delete();
    unstable = 0; bad_sel = 0; done_cyc = -1; hold_cyc = -2;
    z_ce_seen = 0; z_moves = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    rst = 1'b0;
  endtask

  task automatic run_to_end(input int budget, input bit pulse, output int n);
    n = budget;
    for (int k = 1; k <= budget; k++) begin
      if (pulse) start = busy & k[0];
      @(posedge clk);
      #1;
      if (done || error) begin
        n = k;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check("run_budget", 32'd0, 32'd1);
  endtask

  task automatic check_words(input string tag);
    logic [31:0] exp;
    check({tag, "_nwords"}, b_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
      exp = ((2 * i + 1) << 16) | (2 * i);
      check({tag, "_addr"}, b_addr[i], 32'h8000_0000 + 4 * i);
      check({tag, "_data"}, b_data[i], exp);
    end
  endtask

  int n, ref_n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; zstart = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold",  hold, 1);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_error", error, 0);
    check("rst_we",    {ram_ce, ram_we}, 0);
    check("rst_sel",   ram_sel, 0);
    check("rst_faddr", faddr, 0);
    check("rst_raddr", ram_addr, 32'h8000_0000);
    check("rst_prog",  prog, 0);

    // Auto-start copy with the delayed-ready Flash model.
    clear_mon();
    rst = 1'b0;
    run_to_end(400, 1'b0, n);
    repeat (2) @(posedge clk);
    #1;
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_hold", hold, 0);
    check("t1_prog", prog, 4);
    check("t1_done_hold_same_cycle", done_cyc, hold_cyc);
    check_words("t1");
    for (int i = 0; i < b_len.size(); i++) check("t1_wr_len", b_len[i], WRC);
    check("t1_stable", unstable, 0);
    check("t1_sel", bad_sel, 0);

    // Ready tied high: exact per-word period and total latency.
    mode = 1;
    apply_reset();
    run_to_end(400, 1'b0, n);
    ref_n = n;
    repeat (2) @(posedge clk);
    #1;
    check("t2_latency", n, COPY_LAT);
    check_words("t2");
    for (int i = 0; i + 1 < b_start.size(); i++)
      check("t2_period", b_start[i + 1] - b_start[i], WORD_PERIOD);
    for (int i = 0; i < b_len.size(); i++) check("t2_wr_len", b_len[i], WRC);
    check("t2_stable", unstable, 0);

    // start_i pulsed during the copy must not change anything.
    apply_reset();
    run_to_end(400, 1'b1, n);
    check("t6_latency", n, COPY_LAT);
    check("t6_same_as_unpulsed", n, ref_n);
    check("t6_prog", prog, 4);

    // Stuck-low ready: timeout, then recovery via start_i.
    mode = 2;
    apply_reset();
    run_to_end(400, 1'b0, n);
    check("t3_err_latency", n, ERR_LAT);
    check("t3_error", error, 1);
    check("t3_done", done, 0);
    check("t3_busy", busy, 0);
    check("t3_hold", hold, 1);
    check("t3_no_write", b_addr.size(), 0);
    check("t3_faddr", faddr, 0);
    mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t3_restart_error", error, 0);
    check("t3_restart_busy", busy, 1);
    check("t3_restart_hold", hold, 1);
    run_to_end(400, 1'b0, n);
    repeat (2) @(posedge clk);
    #1;
    check("t3_rec_done", done, 1);
    check("t3_rec_prog", prog, 4);
    check_words("t3");

    // Reset asserted during the write of word 2.
    mode = 1;
    apply_reset();
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (ram_we && ram_addr == 32'h8000_0008) begin
        n = 1;
        break;
      end
    end
    check("t4_reached_word2", n, 1);
    check("t4_word2_data", ram_data, 32'h0005_0004);
    rst = 1'b1;
    #1;
    check("t4_we_drop", {ram_ce, ram_we}, 0);
    check("t4_hold", hold, 1);
    check("t4_busy", busy, 0);
    check("t4_prog", prog, 0);
    check("t4_raddr", ram_addr, 32'h8000_0000);
    check("t4_faddr", faddr, 0);
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (ram_we) begin
        n = 1;
        break;
      end
    end
    check("t4_rewrite_seen", n, 1);
    check("t4_rewrite_addr", ram_addr, 32'h8000_0000);
    check("t4_rewrite_data", ram_data, 32'h0001_0000);
    check("t4_rewrite_prog", prog, 0);

    // WORD_COUNT=0 instance without auto-start.
    apply_reset();
    repeat (10) @(posedge clk);
    #1;
    check("t5_idle_busy", z_busy, 0);
    check("t5_idle_done", z_done, 0);
    check("t5_idle_hold", z_hold, 1);
    zstart = 1'b1;
    @(posedge clk);
    #1;
    zstart = 1'b0;
    check("t5_done", z_done, 1);
    check("t5_hold", z_hold, 0);
    check("t5_busy", z_busy, 0);
    check("t5_prog", z_prog, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_no_ce", z_ce_seen, 0);
    check("t5_no_faddr_move", z_moves, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
